// File: rtl/fix_to_flt_engine_if.sv
// fix_to_flt_engine_if: start/ack handshake plus byte-wide data-memory bus for the converter
interface fix_to_flt_engine_if #(parameter int AW = 8);
    logic          start;
    logic          ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    modport master (input start, mem_rdata, output ack, mem_addr, mem_wdata, mem_we);
    modport slave  (output start, mem_rdata, input ack, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/fix_to_flt_engine.sv
// fix_to_flt_engine: signed 8.8 fixed point in memory -> truncated IEEE binary16 written back
module fix_to_flt_engine #(
    parameter int AW       = 8,
    parameter int ADDR_IN  = 0,
    parameter int ADDR_OUT = 2
) (
    input logic                 clk,
    input logic                 reset,
    fix_to_flt_engine_if.master bus
);
    typedef enum logic [3:0] {IDLE, RD_LO, RD_HI, ABS, NORM, PACK, WR_LO, WR_HI, DONE} state_t;
    state_t        state_q, state_d;
    logic [15:0]   x_q, x_d, mag_q, mag_d, res_q, res_d;
    logic [3:0]    s_q, s_d;
    logic          sign_q, sign_d, ack_q, ack_d;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          we;
    // next state, datapath updates and memory-bus drive decoded from the current state
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        mag_d   = mag_q;
        res_d   = res_q;
        s_d     = s_q;
        sign_d  = sign_q;
        addr    = AW'(ADDR_IN);
        wdata   = 8'h00;
        we      = 1'b0;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d = RD_LO;
                s_d     = 4'd0;
                mag_d   = 16'd0;
            end
            RD_LO: begin
                x_d[7:0] = bus.mem_rdata;
                state_d  = RD_HI;
            end
            RD_HI: begin
                addr      = AW'(ADDR_IN + 1);
                x_d[15:8] = bus.mem_rdata;
                state_d   = ABS;
            end
            ABS: begin
                sign_d  = x_q[15];
                mag_d   = x_q[15] ? (~x_q + 16'd1) : x_q;
                res_d   = 16'h0000;
                state_d = (x_q == 16'd0) ? WR_LO : NORM;
            end
            NORM: if (!mag_q[15]) begin
                mag_d = mag_q << 1;
                s_d   = s_q + 4'd1;
            end else begin
                state_d = PACK;
            end
            PACK: begin
                res_d   = {sign_q, 5'd22 - {1'b0, s_q}, mag_q[14:5]};
                state_d = WR_LO;
            end
            WR_LO: begin
                we      = 1'b1;
                addr    = AW'(ADDR_OUT);
                wdata   = res_q[7:0];
                state_d = WR_HI;
            end
            WR_HI: begin
                we      = 1'b1;
                addr    = AW'(ADDR_OUT + 1);
                wdata   = res_q[15:8];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == DONE);
    end
    // state and datapath registers; reset returns straight to idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= 16'd0;
            mag_q   <= 16'd0;
            res_q   <= 16'd0;
            s_q     <= 4'd0;
            sign_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            mag_q   <= mag_d;
            res_q   <= res_d;
            s_q     <= s_d;
            sign_q  <= sign_d;
            ack_q   <= ack_d;
        end
    end
    assign bus.ack       = ack_q;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_we    = we;
endmodule

// File: tb/tb_fix_to_flt_engine.sv
// tb_fix_to_flt_engine: directed and random conversions against an arithmetic binary16 model
module tb_fix_to_flt_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_lo = 8'h00, in_hi = 8'h00, out_lo = 8'h00, out_hi = 8'h00;
    logic       bad_addr = 1'b0;
    int         n_chk = 0, n_pass = 0;

    fix_to_flt_engine_if #(.AW(8)) bus ();
    fix_to_flt_engine #(.AW(8), .ADDR_IN(0), .ADDR_OUT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign bus.start     = start;
    assign bus.mem_rdata = (bus.mem_addr == 8'd0) ? in_lo :
                           (bus.mem_addr == 8'd1) ? in_hi :
                           (bus.mem_addr == 8'd2) ? out_lo :
                           (bus.mem_addr == 8'd3) ? out_hi : 8'hxx;

    // byte memory: only the two output bytes are writable; any other access is flagged
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr == 8'd2) out_lo <= bus.mem_wdata;
        if (bus.mem_we && bus.mem_addr == 8'd3) out_hi <= bus.mem_wdata;
        if (bus.mem_addr > 8'd3 || (bus.mem_we && bus.mem_addr < 8'd2)) bad_addr <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // binary16 by value: exponent from the position of the top set bit, truncated fraction
    function automatic logic [15:0] ref_flt(input logic [15:0] x, output int lat);
        int v, m, e;
        v = $signed(x);
        m = (v < 0) ? -v : v;
        if (m == 0) begin
            lat = 5;
            return 16'h0000;
        end
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        lat = 7 + (15 - e);
        return {x[15], 5'(e + 7), 10'(((m << 10) >> e) & 'h3FF)};
    endfunction

    // one conversion: start sampled at edge E0, lat = index of the edge after which ack is seen
    task automatic run(input logic [15:0] x, input int pulse_at, output int lat);
        in_lo = x[7:0];
        in_hi = x[15:8];
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk) start = 1'b0;
        while (!bus.ack && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk) start = (lat == pulse_at);
        end
        start = 1'b0;
    endtask

    typedef struct { logic [15:0] x; logic [15:0] y; int lat; } vec_t;
    vec_t vecs[8] = '{
        '{16'h0100, 16'h3C00, 14}, '{16'h0180, 16'h3E00, 14}, '{16'hFF00, 16'hBC00, 14},
        '{16'h0320, 16'h4240, 13}, '{16'h8000, 16'hD800, 7},  '{16'h7FFF, 16'h57FF, 8},
        '{16'h0001, 16'h1C00, 22}, '{16'h0000, 16'h0000, 5}
    };

    initial begin
        int lat, elat;
        logic [15:0] x, y;
        logic [7:0] keep_lo, keep_hi;
        #1;
        chk("rst_ack", bus.ack, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_addr", bus.mem_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        foreach (vecs[i]) begin
            run(vecs[i].x, (vecs[i].x == 16'h0000) ? 3 : 5, lat);
            chk($sformatf("res_%04h", vecs[i].x), {out_hi, out_lo}, vecs[i].y);
            chk($sformatf("lat_%04h", vecs[i].x), lat, vecs[i].lat);
        end
        run(16'h0100, 0, lat);
        keep_lo = out_lo;
        keep_hi = out_hi;
        in_lo = 8'h01;
        in_hi = 8'h00;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_ack", bus.ack, 0);
        chk("rst_mid_we", bus.mem_we, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_mem", {out_hi, out_lo}, {keep_hi, keep_lo});
        run(16'h0280, 0, lat);
        chk("res_0280", {out_hi, out_lo}, 16'h4100);
        chk("lat_0280", lat, 13);
        for (int i = 0; i < 1500; i++) begin
            x = 16'($urandom);
            if (i % 4 == 0) x = x >> $urandom_range(15, 0);
            y = ref_flt(x, elat);
            run(x, 0, lat);
            chk($sformatf("rnd_res_%04h", x), {out_hi, out_lo}, y);
            chk($sformatf("rnd_lat_%04h", x), lat, elat);
        end
        chk("addr_range", bad_addr, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
